// File: rtl/traffic_pkg.sv
// Shared types for the road phase sequencer: lamp phase encoding and FSM state.
package traffic_pkg;

  localparam logic [1:0] PH_ALL_RED = 2'b00;
  localparam logic [1:0] PH_GREEN   = 2'b01;
  localparam logic [1:0] PH_YELLOW  = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    GREEN,
    YELLOW,
    ALL_RED
  } state_e;

  // IDLE shows all-red so the intersection is safe before the first tick.
  function automatic logic [1:0] phase_of(input state_e st);
    case (st)
      GREEN:   phase_of = PH_GREEN;
      YELLOW:  phase_of = PH_YELLOW;
      default: phase_of = PH_ALL_RED;
    endcase
  endfunction

endpackage

// File: rtl/rr_next_sel.sv
// Rotate-priority search: first road after cur (wrapping) whose request bit is set.
module rr_next_sel #(
  parameter  int N_ROADS = 4,
  localparam int ROAD_W  = $clog2(N_ROADS)
) (
  input  logic [ROAD_W-1:0]  cur,
  input  logic [N_ROADS-1:0] req,
  output logic               found,
  output logic [ROAD_W-1:0]  next
);

  logic [ROAD_W-1:0] idx;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    found = 1'b0;
    next  = cur;
    idx   = cur;
    // Walk from farthest to nearest so the nearest requesting road wins; own road is never visited.
    for (int k = N_ROADS - 1; k >= 1; k--) begin
      idx = ROAD_W'((int'(cur) + k) % N_ROADS);
      if (req[idx]) begin
        found = 1'b1;
        next  = idx;
      end
    end
  end

endmodule

// File: rtl/road_phase_sequencer.sv
// Round-robin traffic phase sequencer with demand skipping.
// Optional emergency override enabled by defining PRIORITY_OVERRIDE_EN.
module road_phase_sequencer
  import traffic_pkg::*;
#(
  parameter  int N_ROADS  = 4,
  parameter  int CNT_W    = 6,
  parameter  int YELLOW_T = 3,
  localparam int ROAD_W   = $clog2(N_ROADS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               seq_en,
  input  logic               tick,
  input  logic [CNT_W-1:0]   cfg_green,
  input  logic [N_ROADS-1:0] road_req,
`ifdef PRIORITY_OVERRIDE_EN
  input  logic               emg_req,
  input  logic [ROAD_W-1:0]  emg_road,
`endif
  output logic [ROAD_W-1:0]  current_road,
  output logic [1:0]         phase,
  output logic [CNT_W-1:0]   time_left,
  output logic               road_switch
);

  localparam logic [CNT_W-1:0] YELLOW_LEN = CNT_W'(YELLOW_T);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [ROAD_W-1:0] road_q, road_d;
  logic [ROAD_W-1:0] target_q, target_d;
  logic              switch_q, switch_d;

  logic              adv;
  logic [CNT_W-1:0]  green_len;
  logic              rr_found;
  logic [ROAD_W-1:0] rr_next;
  logic              emg_valid;
  logic [ROAD_W-1:0] emg_tgt;

  assign adv       = seq_en && tick;
  assign green_len = (cfg_green == '0) ? ONE : cfg_green;

`ifdef PRIORITY_OVERRIDE_EN
  // Out-of-range emergency targets are ignored outright.
  assign emg_valid = emg_req && (int'(emg_road) < N_ROADS);
  assign emg_tgt   = emg_road;
`else
  assign emg_valid = 1'b0;
  assign emg_tgt   = '0;
`endif

  rr_next_sel #(.N_ROADS(N_ROADS)) u_rr_next_sel (
    .cur   (road_q),
    .req   (road_req),
    .found (rr_found),
    .next  (rr_next)
  );

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    road_d   = road_q;
    target_d = target_q;
    switch_d = 1'b0;
    if (seq_en) begin
      if (emg_valid && (state_q == YELLOW || state_q == ALL_RED))
        target_d = emg_tgt;
      if (adv) begin
        case (state_q)
          IDLE: begin
            // The first green counts as a new road, so it pulses road_switch too.
            state_d  = GREEN;
            road_d   = '0;
            timer_d  = green_len;
            switch_d = 1'b1;
          end
          GREEN: begin
            if (emg_valid && emg_tgt != road_q) begin
              state_d  = YELLOW;
              timer_d  = YELLOW_LEN;
              target_d = emg_tgt;
            end else if (emg_valid) begin
              timer_d = timer_q;
            end else if (timer_q == ONE) begin
              if (rr_found) begin
                state_d  = YELLOW;
                timer_d  = YELLOW_LEN;
                target_d = rr_next;
              end else begin
                timer_d = green_len;
              end
            end else begin
              timer_d = timer_q - ONE;
            end
          end
          YELLOW: begin
            if (timer_q == ONE) begin
              state_d = ALL_RED;
              timer_d = ONE;
            end else begin
              timer_d = timer_q - ONE;
            end
          end
          ALL_RED: begin
            state_d  = GREEN;
            road_d   = target_d;
            timer_d  = green_len;
            switch_d = 1'b1;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      road_q   <= '0;
      target_q <= '0;
      switch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      road_q   <= road_d;
      target_q <= target_d;
      switch_q <= switch_d;
    end
  end

  assign current_road = road_q;
  assign phase        = phase_of(state_q);
  assign time_left    = timer_q;
  assign road_switch  = switch_q;

endmodule

// File: tb/tb_road_phase_sequencer.sv
// Self-checking bench for road_phase_sequencer: per-cycle model compare plus directed literal checks.
module tb_road_phase_sequencer;

  localparam int N  = 4;
  localparam int CW = 6;
  localparam int YT = 3;
  localparam int RW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          seq_en = 1'b0;
  logic          tick = 1'b0;
  logic [CW-1:0] cfg_green = 6'd5;
  logic [N-1:0]  road_req = 4'b1111;
  logic [RW-1:0] current_road;
  logic [1:0]    phase;
  logic [CW-1:0] time_left;
  logic          road_switch;
`ifdef PRIORITY_OVERRIDE_EN
  logic          emg_req = 1'b0;
  logic [RW-1:0] emg_road = '0;
`endif

  road_phase_sequencer #(.N_ROADS(N), .CNT_W(CW), .YELLOW_T(YT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .seq_en       (seq_en),
    .tick         (tick),
    .cfg_green    (cfg_green),
    .road_req     (road_req),
`ifdef PRIORITY_OVERRIDE_EN
    .emg_req      (emg_req),
    .emg_road     (emg_road),
`endif
    .current_road (current_road),
    .phase        (phase),
    .time_left    (time_left),
    .road_switch  (road_switch)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit model_on = 1'b1;
  int sw_log[$];
  int sw_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: 0 idle, 1 green, 2 yellow, 3 all-red; advanced once per enabled tick.
  int m_st = 0, m_road = 0, m_tl = 0, m_tgt = 0;
  bit m_sw = 1'b0;

  function automatic int g_len();
    return (cfg_green == 0) ? 1 : int'(cfg_green);
  endfunction

  function automatic int m_phase();
    return (m_st == 1) ? 1 : (m_st == 2) ? 2 : 0;
  endfunction

  task automatic model_step(input bit adv);
    int pick;
    m_sw = 1'b0;
    if (!rst_n) begin
      m_st = 0; m_road = 0; m_tl = 0; m_tgt = 0;
      return;
    end
    if (!adv) return;
    case (m_st)
      0: begin m_st = 1; m_road = 0; m_tl = g_len(); m_sw = 1'b1; end
      1: begin
        if (m_tl == 1) begin
          pick = -1;
          for (int k = 1; k < N && pick < 0; k++)
            if (road_req[(m_road + k) % N]) pick = (m_road + k) % N;
          if (pick >= 0) begin m_st = 2; m_tl = YT; m_tgt = pick; end
          else m_tl = g_len();
        end else m_tl--;
      end
      2: if (m_tl == 1) begin m_st = 3; m_tl = 1; end else m_tl--;
      default: begin m_st = 1; m_road = m_tgt; m_tl = g_len(); m_sw = 1'b1; end
    endcase
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step(seq_en && tick);
      #1;
      if (model_on) begin
        check("phase", phase, m_phase());
        check("current_road", current_road, m_road);
        check("time_left", time_left, m_tl);
        check("road_switch", road_switch, m_sw);
      end
      if (road_switch) begin
        sw_log.push_back(int'(current_road));
        sw_count++;
      end
    end
  end

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      @(negedge clk);
      @(negedge clk);
    end
  endtask

  task automatic expect_out(input string tag, input int ph, input int rd, input int tl);
    check({tag, ".phase"}, phase, ph);
    check({tag, ".road"}, current_road, rd);
    check({tag, ".time_left"}, time_left, tl);
  endtask

  task automatic expect_log(input string tag, input int exp_q[$]);
    check({tag, ".switch_count"}, sw_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < sw_log.size(); i++)
      check({tag, ".switch_road"}, sw_log[i], exp_q[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // Reset and disabled ticks: nothing moves.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_out("reset", 0, 0, 0);
    do_ticks(10);
    expect_out("disabled", 0, 0, 0);
    check("disabled.switches", sw_count, 0);

    // Full demand: green 5, yellow 3, all-red 1, roads 0,1,2,3,0.
    seq_en = 1'b1;
    sw_log.delete();
    do_ticks(1);
    expect_out("first_green", 1, 0, 5);
    do_ticks(5);
    expect_out("first_yellow", 2, 0, 3);
    do_ticks(3);
    expect_out("first_allred", 0, 0, 1);
    do_ticks(28);
    expect_out("rr_wrap", 1, 0, 5);
    expect_log("rr", '{0, 1, 2, 3, 0});

    // Sparse demand skips roads 1 and 2.
    road_req = 4'b1001;
    sw_log.delete();
    do_ticks(4);
    expect_out("skip_last", 1, 0, 1);
    do_ticks(1);
    expect_out("skip_yellow", 2, 0, 3);
    do_ticks(13);
    expect_out("skip_back", 1, 0, 5);
    expect_log("skip", '{3, 0});

    // Own-road demand only: green extends, no yellow.
    road_req = 4'b0001;
    sw_log.delete();
    do_ticks(5);
    expect_out("solo_reload", 1, 0, 5);
    do_ticks(10);
    expect_out("solo_reload2", 1, 0, 5);
    check("solo.switches", sw_log.size(), 0);

    // Freeze with seq_en low, then 1-tick greens from cfg_green=0.
    do_ticks(3);
    expect_out("pre_freeze", 1, 0, 2);
    @(negedge clk); seq_en = 1'b0;
    do_ticks(20);
    expect_out("frozen", 1, 0, 2);
    seq_en = 1'b1;
    cfg_green = '0;
    road_req = 4'b1111;
    sw_log.delete();
    @(negedge clk);
    expect_out("resumed", 1, 0, 2);
    do_ticks(1);
    expect_out("resume_dec", 1, 0, 1);
    do_ticks(1);
    expect_out("resume_yellow", 2, 0, 3);
    do_ticks(3);
    expect_out("resume_allred", 0, 0, 1);
    do_ticks(1);
    expect_out("zero_green", 1, 1, 1);
    do_ticks(1);
    expect_out("zero_expiry", 2, 1, 3);
    expect_log("zero", '{1});

    // Asynchronous reset mid-yellow returns to idle immediately.
    @(negedge clk); rst_n = 1'b0;
    #1;
    expect_out("async_rst", 0, 0, 0);
    check("async_rst.switch", road_switch, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_ticks(1);
    expect_out("post_rst", 1, 0, 1);

`ifdef PRIORITY_OVERRIDE_EN
    // Emergency override: literal expectations only.
    model_on = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    cfg_green = 6'd5;
    road_req = 4'b1111;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_ticks(10);
    expect_out("emg_pre", 1, 1, 5);
    emg_req = 1'b1;
    emg_road = 2'd3;
    do_ticks(1);
    expect_out("emg_yellow", 2, 1, 3);
    do_ticks(3);
    expect_out("emg_allred", 0, 1, 1);
    do_ticks(1);
    expect_out("emg_green", 1, 3, 5);
    do_ticks(8);
    expect_out("emg_hold", 1, 3, 5);
    emg_req = 1'b0;
    do_ticks(1);
    expect_out("emg_release", 1, 3, 4);
    emg_req = 1'b1;
    emg_road = 2'd0;
    do_ticks(1);
    expect_out("emg_yellow2", 2, 3, 3);
    @(negedge clk); rst_n = 1'b0;
    #1;
    expect_out("emg_rst", 0, 0, 0);
    emg_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
`endif

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
